// File: rtl/dpram.sv
// dpram: true dual-port synchronous RAM with a valid/ready handshake per port; port A has priority.
// Optional macro DPRAM_RESET_CLEAR_EN: the asynchronous reset also clears every memory word.
module dpram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] data_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic                  we_a,
   input  logic                  valid_a,
   output logic                  ready_a,
   output logic [DATA_WIDTH-1:0] q_a,
   input  logic [DATA_WIDTH-1:0] data_b,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic                  we_b,
   input  logic                  valid_b,
   output logic                  ready_b,
   output logic [DATA_WIDTH-1:0] q_b
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  ready_flag;
   logic                  write_conflict;
   logic                  accept_a;
   logic                  accept_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_flag <= 1'b0;
      end else begin
         ready_flag <= 1'b1;
      end
   end

   // Two writes to one word in the same cycle: B is stalled so A's write wins cleanly.
   assign write_conflict = valid_a & we_a & valid_b & we_b & (addr_a == addr_b);
   assign ready_a        = ready_flag;
   assign ready_b        = ready_flag & ~write_conflict;
   assign accept_a       = valid_a & ready_a;
   assign accept_b       = valid_b & ready_b;

   // Reads sample the array before this edge's writes land, giving read-before-write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_a <= '0;
         q_b <= '0;
      end else begin
         if (accept_a && !we_a) begin
            q_a <= mem[addr_a];
         end
         if (accept_b && !we_b) begin
            q_b <= mem[addr_b];
         end
      end
   end

`ifdef DPRAM_RESET_CLEAR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (accept_a && we_a) begin
            mem[addr_a] <= data_a;
         end
         if (accept_b && we_b) begin
            mem[addr_b] <= data_b;
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (accept_a && we_a) begin
         mem[addr_a] <= data_a;
      end
      if (accept_b && we_b) begin
         mem[addr_b] <= data_b;
      end
   end
`endif

endmodule

// File: tb/tb_dpram.sv
// tb_dpram: randomized self-checking bench for dpram against an array-based reference model.
// Exercises reset, cross-port traffic, read-during-write, write-write collisions and mid-traffic reset.
module tb_dpram;

   localparam int DW    = 8;
   localparam int AW    = 6;
   localparam int DEPTH = 64;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b1;
   logic [DW-1:0] data_a  = '0;
   logic [AW-1:0] addr_a  = '0;
   logic          we_a    = 1'b0;
   logic          valid_a = 1'b0;
   logic [DW-1:0] data_b  = '0;
   logic [AW-1:0] addr_b  = '0;
   logic          we_b    = 1'b0;
   logic          valid_b = 1'b0;
   logic          ready_a;
   logic          ready_b;
   logic [DW-1:0] q_a;
   logic [DW-1:0] q_b;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] model_mem [DEPTH];
   logic [DW-1:0] exp_qa      = '0;
   logic [DW-1:0] exp_qb      = '0;
   logic          ready_model = 1'b0;

   dpram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_a  (data_a),
      .addr_a  (addr_a),
      .we_a    (we_a),
      .valid_a (valid_a),
      .ready_a (ready_a),
      .q_a     (q_a),
      .data_b  (data_b),
      .addr_b  (addr_b),
      .we_b    (we_b),
      .valid_b (valid_b),
      .ready_b (ready_b),
      .q_b     (q_b)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One bus cycle: drive both ports, check ready, update the model by the spec rules, check q.
   task automatic applyStimulus(input logic va, input logic wa, input logic [AW-1:0] aa,
                                input logic [DW-1:0] da, input logic vb, input logic wb,
                                input logic [AW-1:0] ab, input logic [DW-1:0] db);
      logic er_a;
      logic er_b;
      logic acc_a;
      logic acc_b;
      @(negedge clk);
      valid_a = va; we_a = wa; addr_a = aa; data_a = da;
      valid_b = vb; we_b = wb; addr_b = ab; data_b = db;
      #1;
      er_a = ready_model;
      er_b = ready_model && !(va && wa && vb && wb && (aa == ab));
      checkOutput("ready_a", 32'(ready_a), 32'(er_a));
      checkOutput("ready_b", 32'(ready_b), 32'(er_b));
      acc_a = va && er_a;
      acc_b = vb && er_b;
      if (acc_a && !wa) exp_qa = model_mem[aa];
      if (acc_b && !wb) exp_qb = model_mem[ab];
      if (acc_a && wa) model_mem[aa] = da;
      if (acc_b && wb) model_mem[ab] = db;
      @(posedge clk);
      #1;
      ready_model = 1'b1;
      checkOutput("q_a", 32'(q_a), 32'(exp_qa));
      checkOutput("q_b", 32'(q_b), 32'(exp_qb));
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic randomCycle(input logic narrow);
      logic [AW-1:0] ra;
      logic [AW-1:0] rb;
      ra = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
      rb = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
      applyStimulus(1'($urandom), 1'($urandom), ra, DW'($urandom),
                    1'($urandom), 1'($urandom), rb, DW'($urandom));
   endtask

   // Asynchronous reset pulse off the clock edge; a write offered on the flag edge must be ignored.
   task automatic applyReset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_ready_a", 32'(ready_a), 32'd0);
      checkOutput("rst_ready_b", 32'(ready_b), 32'd0);
      checkOutput("rst_q_a", 32'(q_a), 32'd0);
      checkOutput("rst_q_b", 32'(q_b), 32'd0);
      exp_qa      = '0;
      exp_qb      = '0;
      ready_model = 1'b0;
`ifdef DPRAM_RESET_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
`endif
      valid_a = 1'b0;
      valid_b = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("hold_ready_a", 32'(ready_a), 32'd0);
      checkOutput("hold_ready_b", 32'(ready_b), 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      valid_a = 1'b1; we_a = 1'b1; addr_a = AW'(0); data_a = 8'hEE;
      #1;
      checkOutput("rel_ready_a", 32'(ready_a), 32'd0);
      @(posedge clk);
      #1;
      valid_a     = 1'b0;
      we_a        = 1'b0;
      ready_model = 1'b1;
      checkOutput("up_ready_a", 32'(ready_a), 32'd1);
      checkOutput("up_ready_b", 32'(ready_b), 32'd1);
      checkOutput("up_q_a", 32'(q_a), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      applyReset();

      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, 1'b1, AW'(i), DW'($urandom), 1'b0, 1'b0, '0, '0);
      end

      applyStimulus(1'b1, 1'b1, 6'h05, 8'hA5, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b1, 1'b0, 6'h05, 8'h00, 1'b0, 1'b0, '0, '0);
      checkOutput("dir_q_a_A5", 32'(q_a), 32'hA5);
      idleCycle();

      applyStimulus(1'b1, 1'b1, 6'h10, 8'h3C, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 6'h10, 8'h00);
      checkOutput("dir_q_b_3C", 32'(q_b), 32'h3C);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 6'h20, 8'h77);
      applyStimulus(1'b1, 1'b0, 6'h20, 8'h00, 1'b0, 1'b0, '0, '0);
      checkOutput("dir_q_a_77", 32'(q_a), 32'h77);

      applyStimulus(1'b1, 1'b1, 6'h08, 8'h11, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b1, 1'b1, 6'h08, 8'h22, 1'b1, 1'b0, 6'h08, 8'h00);
      checkOutput("rbw_old_11", 32'(q_b), 32'h11);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 6'h08, 8'h00);
      checkOutput("rbw_new_22", 32'(q_b), 32'h22);

      applyStimulus(1'b1, 1'b1, 6'h30, 8'hAA, 1'b1, 1'b1, 6'h30, 8'hBB);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 6'h30, 8'hBB);
      applyStimulus(1'b1, 1'b0, 6'h30, 8'h00, 1'b0, 1'b0, '0, '0);
      checkOutput("coll_final_BB", 32'(q_a), 32'hBB);

      for (int i = 0; i < 200; i++) randomCycle(i[0]);

      for (int i = 0; i < 10; i++) randomCycle(1'b0);
      applyStimulus(1'b1, 1'b1, 6'h05, 8'h5A, 1'b1, 1'b0, 6'h06, 8'h00);
      applyReset();
      applyStimulus(1'b1, 1'b0, 6'h05, 8'h00, 1'b0, 1'b0, '0, '0);
`ifdef DPRAM_RESET_CLEAR_EN
      checkOutput("post_rst_05", 32'(q_a), 32'h00);
`else
      checkOutput("post_rst_05", 32'(q_a), 32'h5A);
`endif
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(DEPTH - 1 - i), '0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
